id_ex_operand_stage: RTL

ID/EX pipeline register and EX-stage operand selector for the 5-stage ARM pipeline. Captures decoded operands and control from ID each cycle and presents `Rn_EX`/`Rm_EX` to the forwarding unit. Consumes that unit's `FWDA`/`FWDB` codes to build the ALU operands and store data. Also detects load-use hazards, inserts the one-cycle bubble, and counts the bubbles inserted.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/fwd_mux3.sv | 24 ++
 rtl/id_ex_operand_stage.sv | 117 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the EX-stage datapath: ALU op encoding, forwarding codes,
// and the zero register number used to make bubbles invisible to forwarding.
package cpu_pkg;

  localparam logic [4:0] XZR = 5'd31;

  typedef enum logic [2:0] {
    ALU_AND   = 3'd0,
    ALU_ORR   = 3'd1,
    ALU_ADD   = 3'd2,
    ALU_SUB   = 3'd3,
    ALU_PASSB = 3'd4
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/fwd_mux3.sv
// 3:1 operand forwarding mux. The unused code 2'b11 falls back to the
// registered operand so a stray code can never inject a bogus value.
module fwd_mux3
  import cpu_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] reg_data,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] out_data
);

  // select the freshest copy of the operand
  always_comb begin
    case (fwd_sel_t'(sel))
      FWD_MEM: out_data = mem_data;
      FWD_WB:  out_data = wb_data;
      default: out_data = reg_data;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX operand forwarding, load-use hazard
// detection and a saturating count of the bubbles that hazard inserts.
module id_ex_operand_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_ID,
  input  logic [4:0]        Rn_ID,
  input  logic [4:0]        Rm_ID,
  input  logic [4:0]        Rd_ID,
  input  logic [DATA_W-1:0] RdData1_ID,
  input  logic [DATA_W-1:0] RdData2_ID,
  input  logic [DATA_W-1:0] Imm_ID,
  input  logic              ALUSrc_ID,
  input  logic [2:0]        ALUOp_ID,
  input  logic              RegWrite_ID,
  input  logic              MemRead_ID,
  input  logic              MemWrite_ID,
  input  logic              flush_EX,
  input  logic              hold_EX,
  input  logic [1:0]        FWDA,
  input  logic [1:0]        FWDB,
  input  logic [DATA_W-1:0] aluResult_MEM,
  input  logic [DATA_W-1:0] wbData_WB,
  output logic [4:0]        Rn_EX,
  output logic [4:0]        Rm_EX,
  output logic [4:0]        targetReg_EX,
  output logic [DATA_W-1:0] opA_EX,
  output logic [DATA_W-1:0] opB_EX,
  output logic [DATA_W-1:0] storeData_EX,
  output logic [2:0]        ALUOp_EX,
  output logic              RegWrite_EX,
  output logic              MemRead_EX,
  output logic              MemWrite_EX,
  output logic              valid_EX,
  output logic              loadUse_stall,
  output logic [CNT_W-1:0]  bubble_count
);

  logic [DATA_W-1:0] rd_data1_ex, rd_data2_ex, imm_ex;
  logic              alu_src_ex;
  logic [DATA_W-1:0] fwd_rn, fwd_rm;
  logic              write_bubble, count_bubble;

  // A load in EX feeding the instruction in ID must wait one cycle. Loads
  // to XZR produce nothing, so they never stall.
  assign loadUse_stall = valid_EX & MemRead_EX & (targetReg_EX != XZR) & valid_ID &
                         ((targetReg_EX == Rn_ID) | (targetReg_EX == Rm_ID));

  // flush beats hold; a stall only takes effect when EX is free to move
  assign write_bubble = flush_EX | (!hold_EX & loadUse_stall);
  assign count_bubble = !flush_EX & !hold_EX & loadUse_stall;

  // pipeline register: reset > flush > hold > load-use bubble > capture
  always_ff @(posedge clk) begin
    if (!reset_n || write_bubble) begin
      valid_EX     <= 1'b0;
      RegWrite_EX  <= 1'b0;
      MemRead_EX   <= 1'b0;
      MemWrite_EX  <= 1'b0;
      alu_src_ex   <= 1'b0;
      ALUOp_EX     <= '0;
      Rn_EX        <= XZR;
      Rm_EX        <= XZR;
      targetReg_EX <= XZR;
      rd_data1_ex  <= '0;
      rd_data2_ex  <= '0;
      imm_ex       <= '0;
    end else if (!hold_EX) begin
      valid_EX     <= valid_ID;
      RegWrite_EX  <= RegWrite_ID & valid_ID;
      MemRead_EX   <= MemRead_ID & valid_ID;
      MemWrite_EX  <= MemWrite_ID & valid_ID;
      alu_src_ex   <= ALUSrc_ID;
      ALUOp_EX     <= ALUOp_ID;
      Rn_EX        <= Rn_ID;
      Rm_EX        <= Rm_ID;
      targetReg_EX <= Rd_ID;
      rd_data1_ex  <= RdData1_ID;
      rd_data2_ex  <= RdData2_ID;
      imm_ex       <= Imm_ID;
    end
  end

  // saturating count of load-use bubbles (flush bubbles are not counted)
  always_ff @(posedge clk) begin
    if (!reset_n)
      bubble_count <= '0;
    else if (count_bubble && bubble_count != {CNT_W{1'b1}})
      bubble_count <= bubble_count + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  fwd_mux3 #(.DATA_W(DATA_W)) u_fwd_a (
    .sel      (FWDA),
    .reg_data (rd_data1_ex),
    .mem_data (aluResult_MEM),
    .wb_data  (wbData_WB),
    .out_data (fwd_rn)
  );

  fwd_mux3 #(.DATA_W(DATA_W)) u_fwd_b (
    .sel      (FWDB),
    .reg_data (rd_data2_ex),
    .mem_data (aluResult_MEM),
    .wb_data  (wbData_WB),
    .out_data (fwd_rm)
  );

  assign opA_EX       = fwd_rn;
  assign storeData_EX = fwd_rm;
  assign opB_EX       = alu_src_ex ? imm_ex : fwd_rm;

endmodule
